cla_sub_pipe: RTL and testbench
===============================

Name: cla_sub_pipe

Overview:
- Two-stage pipelined carry-lookahead subtractor: computes d = a - b - bin, with borrow-out and signed-overflow flags.
- Sits in the FIR datapath wherever differences are needed: symmetric-tap pre-subtraction, error terms, decimator difference stages.
- Implements the inverse arithmetic direction of the team's lookahead adder, using the same generate/propagate/group-lookahead structure on inverted subtrahend bits.
- Valid/ready handshake on input and output; full throughput under no backpressure.

Parameters:
- N, 16, operand and result width in bits (N >= 4, even).
- LO_W, N/2, width of the low slice resolved in stage 1; the high slice (N-LO_W bits) is resolved in stage 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  minuend, two's complement.
- b  input  N  subtrahend, two's complement.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- d  output  N  difference.
- bout  output  1  unsigned borrow-out (1 when a < b + bin as unsigned).
- ovf  output  1  signed overflow.

Behaviour:
- Arithmetic: d = a + ~b + ~bin, mod 2^N. c_in = ~bin; bout = ~carry_out.
- ovf = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]), using the unsaturated d.
- Per bit: p = a ^ ~b, g = a & ~b. Within each slice: group prefix P/G, ripple-free carry c[i+1] = G[i] | (c_in & P[i]).
- Stage 1 (S1 register), on acceptance, captures:
  - low-slice difference bits;
  - low-slice carry-out;
  - high-slice a and ~b;
  - a[N-1] and b[N-1] for ovf.
- Stage 2 (S2 register = outputs) computes the high slice using S1 carry as c_in, and registers d, bout, ovf.
- Latency: exactly 2 cycles from in_valid && in_ready to out_valid. Throughput: 1 result/cycle.
- Handshake:
  - v1, v2 are the S1/S2 valid bits; out_valid = v2.
  - s2_ready = !v2 || out_ready.
  - s1_ready = !v1 || s2_ready.
  - in_ready = s1_ready (combinational path from out_ready is allowed).
- Transfers:
  - S1 loads when in_valid && in_ready.
  - S2 loads when v1 && s2_ready.
  - A stage holding valid data with its downstream stalled keeps its data and valid bit unchanged.
- Simultaneous events: in the same cycle, S2 accepts from S1, S1 accepts new input, and the output handshake completes; no bubble, no drop, no duplication.
- Output stability: while out_valid && !out_ready, d/bout/ovf are held constant.
- Reset:
  - v1, v2 -> 0; d -> 0; bout -> 0; ovf -> 0.
  - Mid-operation reset discards in-flight data.
  - in_ready is 1 in the first cycle after reset deasserts.
- Boundaries:
  - a = b, bin = 0: d = 0, bout = 0.
  - a = 0, b = 0, bin = 1: d = all-ones, bout = 1.
  - Carry crossing the slice boundary must resolve correctly, e.g. N=16, a = 0x0100, b = 0x0001: d = 0x00FF.

Optional Feature:
- Macro: CLA_SUB_SAT_EN.
- Defined: when ovf = 1, d is clamped. If a[N-1] = 0, d = 0x7FF..F; otherwise d = 0x800..0. ovf still reports the overflow; bout is unchanged.
- Undefined: d wraps modulo 2^N; no clamp logic is instantiated.
- Latency is identical in both builds.

Decomposition:
- Shared package fir_arith_pkg holds:
  - default width constant FIR_DW = 16;
  - saturation constants SAT_MAX(N) and SAT_MIN(N) as functions;
  - the generate/propagate pair typedef reused by adder and subtractor.
- One natural sub-module: cla_slice, a combinational W-bit lookahead slice (inputs x, y, cin; outputs s, cout). It is instantiated twice, for the low and high slices; the pipeline/handshake wrapper lives in cla_sub_pipe.

Test Plan:
- Single op, N=16: a = 0x1234, b = 0x0234, bin = 0 -> two cycles later d = 0x1000, bout = 0, ovf = 0.
- Borrow across slices: a = 0x0100, b = 0x0001, bin = 0 -> d = 0x00FF. Then a = 0, b = 0, bin = 1 -> d = 0xFFFF, bout = 1.
- Signed overflow: a = 0x8000, b = 0x0001 -> ovf = 1. Default build d = 0x7FFF (wrap); with CLA_SUB_SAT_EN, d = 0x8000 (clamp).
- Backpressure: stream 8 ops with out_ready toggling 1,0,0,1,...
  - Every result appears in order exactly once.
  - d is stable while stalled.
  - in_ready drops only when both stages hold data and out_ready = 0.
- Full throughput: in_valid and out_ready held high for 100 random pairs -> 100 results on consecutive cycles after 2-cycle latency, each matching a - b - bin from the scoreboard.
- Reset mid-stream: assert rst with v1 = v2 = 1 -> next cycle out_valid = 0, d = 0, in_ready = 1; no stale result emerges afterwards.

Source files
------------

// File: rtl/fir_arith_pkg.sv
// fir_arith_pkg: shared FIR arithmetic width, saturation constants and generate/propagate pair type
package fir_arith_pkg;
  localparam int FIR_DW = 16;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic logic [63:0] SAT_MAX(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] SAT_MIN(input int n);
    return 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational W-bit lookahead slice, carries taken from group prefix G/P and cin
module cla_slice
  import fir_arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  gp_t w_bit, w_grp;
  // group prefix over bits below k gives carry into bit k as G | (cin & P)
  always_comb begin
    s = '0;
    w_bit = '{g: 1'b0, p: 1'b0};
    w_grp = '{g: 1'b0, p: 1'b1};
    for (int k = 0; k < W; k++) begin
      w_bit = '{g: x[k] & y[k], p: x[k] ^ y[k]};
      s[k] = w_bit.p ^ (w_grp.g | (cin & w_grp.p));
      w_grp = '{g: w_bit.g | (w_bit.p & w_grp.g), p: w_bit.p & w_grp.p};
    end
    cout = w_grp.g | (cin & w_grp.p);
  end
endmodule

// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined lookahead subtractor d = a - b - bin; define CLA_SUB_SAT_EN to clamp d on signed overflow
module cla_sub_pipe
  import fir_arith_pkg::*;
#(
  parameter int N    = FIR_DW,
  parameter int LO_W = N / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);
  localparam int HI_W = N - LO_W;
  logic            r_v1, r_v2, r_lo_c, r_a_msb, r_b_msb;
  logic [LO_W-1:0] r_lo_d;
  logic [HI_W-1:0] r_hi_a, r_hi_nb;
  logic [LO_W-1:0] w_lo_s;
  logic [HI_W-1:0] w_hi_s;
  logic            w_lo_c, w_hi_c, w_ovf, w_s1_ready, w_s2_ready;
  logic [N-1:0]    w_d;
  assign w_s2_ready = !r_v2 || out_ready;
  assign w_s1_ready = !r_v1 || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign out_valid  = r_v2;
  cla_slice #(.W(LO_W)) u_lo (
    .x(a[LO_W-1:0]), .y(~b[LO_W-1:0]), .cin(~bin), .s(w_lo_s), .cout(w_lo_c)
  );
  cla_slice #(.W(HI_W)) u_hi (
    .x(r_hi_a), .y(r_hi_nb), .cin(r_lo_c), .s(w_hi_s), .cout(w_hi_c)
  );
  assign w_ovf = (r_a_msb != r_b_msb) && (w_hi_s[HI_W-1] != r_a_msb);
`ifdef CLA_SUB_SAT_EN
  localparam logic [N-1:0] SAT_HI = N'(SAT_MAX(N));
  localparam logic [N-1:0] SAT_LO = N'(SAT_MIN(N));
  assign w_d = w_ovf ? (r_a_msb ? SAT_LO : SAT_HI) : {w_hi_s, r_lo_d};
`else
  assign w_d = {w_hi_s, r_lo_d};
`endif
  // stage 1: resolve low slice, park high-slice operands and sign bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else begin
      if (w_s1_ready) r_v1 <= in_valid;
      if (in_valid && w_s1_ready) begin
        r_lo_d  <= w_lo_s;
        r_lo_c  <= w_lo_c;
        r_hi_a  <= a[N-1:LO_W];
        r_hi_nb <= ~b[N-1:LO_W];
        r_a_msb <= a[N-1];
        r_b_msb <= b[N-1];
      end
    end
  end
  // stage 2: resolve high slice from stage-1 carry and register the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (w_s2_ready) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        d    <= w_d;
        bout <= ~w_hi_c;
        ovf  <= w_ovf;
      end
    end
  end
endmodule

// File: tb/tb_cla_sub_pipe.sv
// tb_cla_sub_pipe: randomized and directed checks of cla_sub_pipe against an arithmetic reference model
module tb_cla_sub_pipe;
  localparam int N = 16;
  typedef struct {
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;
  int           n_vec = 0;
  int           n_err = 0;
  exp_t         q[$];
  always #5 clk = ~clk;
  cla_sub_pipe #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    exp_t m;
    int sd;
    logic [N:0] u;
    u = {1'b0, x} - {1'b0, y} - (N+1)'(c);
    sd = int'($signed(x)) - int'($signed(y)) - int'(c);
    m.d = u[N-1:0];
    m.bout = u[N];
    m.ovf = (sd > 32767) || (sd < -32768);
`ifdef CLA_SUB_SAT_EN
    if (m.ovf) m.d = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
    return m;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || d !== '0 || bout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: out_valid=%b d=%h bout=%b ovf=%b in_ready=%b, want 0 0000 0 0 1", out_valid, d, bout, ovf, in_ready);
    end
  endtask
  task automatic test_directed();
    logic [N-1:0] ta[7] = '{16'h1234, 16'h0100, 16'h0000, 16'h8000, 16'h5A5A, 16'h7FFF, 16'h00FF};
    logic [N-1:0] tb_[7] = '{16'h0234, 16'h0001, 16'h0000, 16'h0001, 16'h5A5A, 16'hFFFF, 16'h0100};
    logic         tc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e = model(ta[i], tb_[i], tc[i]);
      @(posedge clk);
      #1 in_valid = 1'b1; a = ta[i]; b = tb_[i]; bin = tc[i];
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid=%b want 0 after 1 cycle", i, out_valid);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || d !== e.d || bout !== e.bout || ovf !== e.ovf) begin
        n_err++;
        $display("FAIL directed[%0d] a=%h b=%h bin=%b: got v=%b d=%h bout=%b ovf=%b want v=1 d=%h bout=%b ovf=%b",
                 i, ta[i], tb_[i], tc[i], out_valid, d, bout, ovf, e.d, e.bout, e.ovf);
      end
    end
    @(posedge clk);
  endtask
  task automatic test_backpressure();
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   sent = 0, recv = 0, cyc = 0;
    logic have_op = 1'b0;
    logic want_rdy;
    exp_t e;
    q.delete();
    while (recv < 8 && cyc < 200) begin
      @(posedge clk);
      #1;
      if (!have_op && sent < 8) begin
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
        have_op = 1'b1;
      end
      in_valid = have_op;
      out_ready = pat[cyc % 4];
      @(negedge clk);
      want_rdy = !(q.size() == 2 && !out_ready);
      n_vec++;
      if (in_ready !== want_rdy) begin
        n_err++;
        $display("FAIL bp_in_ready cyc=%0d: got %b want %b (fill=%0d)", cyc, in_ready, want_rdy, q.size());
      end
      if (out_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL bp_spurious cyc=%0d: out_valid with nothing in flight, d=%h", cyc, d);
        end else if (d !== q[0].d || bout !== q[0].bout || ovf !== q[0].ovf) begin
          n_err++;
          $display("FAIL bp_data cyc=%0d: got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                   cyc, d, bout, ovf, q[0].d, q[0].bout, q[0].ovf);
        end
        if (out_ready && q.size() != 0) begin
          e = q.pop_front();
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
        have_op = 1'b0;
      end
      cyc++;
    end
    n_vec++;
    if (recv != 8 || q.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: received %0d leftover %0d, want 8 and 0", recv, q.size());
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
  endtask
  task automatic test_throughput();
    exp_t e;
    q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 102; c++) begin
      @(posedge clk);
      #1;
      in_valid = (c < 100);
      a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      if (c % 10 == 0) a = b;
      @(negedge clk);
      if (c < 100) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL tp_in_ready c=%0d: got %b want 1", c, in_ready);
        end
      end
      n_vec++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL tp_latency c=%0d: out_valid=%b want 0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || q.size() == 0) begin
        n_err++;
        $display("FAIL tp_gap c=%0d: out_valid=%b want 1", c, out_valid);
      end else begin
        e = q.pop_front();
        if (d !== e.d || bout !== e.bout || ovf !== e.ovf) begin
          n_err++;
          $display("FAIL tp_data c=%0d: got d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                   c, d, bout, ovf, e.d, e.bout, e.ovf);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic test_reset_midstream();
    q.delete();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; out_ready = 1'b0;
      a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
    end
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_full: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || d !== '0 || bout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b d=%h bout=%b ovf=%b in_ready=%b want 0 0000 0 0 1", out_valid, d, bout, ovf, in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_stale c=%0d: out_valid=%b d=%h want no result", c, out_valid, d);
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
